avalon_mem_responder: RTL
=========================

// Module: avalon_mem_responder
// PURPOSE
//  Memory-side responder for the multicycle MIPS core's data/instruction bus.
//  It accepts read/write requests and stalls them with waitrequest until the
//  access completes. Single-port word RAM with byte enables.
//  Used as the memory model in CPU testbenches and as the on-chip RAM in FPGA builds.
// PARAMETERS
//  MEM_WORDS      1024            depth in 32-bit words (power of two)
//  BASE_ADDR      32'hBFC00000    byte address of word 0
//  WAIT_CYCLES    2               fixed wait states per access (0..15)
//  RAM_INIT_FILE  ""              $readmemh image; empty = all-zero RAM
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  Rst          in   1   synchronous active-high reset
//  address      in   32  byte address of the access
//  read         in   1   read request
//  write        in   1   write request
//  byteenable   in   4   write lane mask; bit i covers bits [8i+7:8i]
//  writedata    in   32  write data
//  readdata     out  32  read data; valid only in the ACK cycle
//  waitrequest  out  1   1 = transaction not complete, master holds request
//  bus_err      out  1   one-cycle pulse in ACK of a faulted access
// BEHAVIOUR
//  Reset: state=IDLE, waitrequest=1, readdata=0, bus_err=0, count=0. RAM
//   contents are not cleared.
//  FSM (state_t): IDLE -> WAIT -> ACK -> IDLE.
//   IDLE: if read|write, latch address/read/write/byteenable/writedata.
//    count<=WAIT_CYCLES. Next state is WAIT, or ACK if WAIT_CYCLES==0.
//   WAIT: count decrements each cycle. Enter ACK on the cycle count reaches 1.
//   ACK: exactly one cycle, then always IDLE. No back-to-back ACK.
//  waitrequest=0 only in ACK. It is 1 in every other state, including idle.
//   It is a registered output.
//  Latency: request seen in IDLE at cycle t. ACK occurs at t+WAIT_CYCLES+1.
//  The master may change inputs during WAIT. Only the values latched in
//   IDLE are used.
//  Write commit: RAM updated on the clock edge entering ACK.
//   Only enabled lanes change. byteenable=0 is a legal no-op.
//  Read: readdata is loaded on the edge entering ACK. It is held at 0
//   outside ACK.
//  Faults: any of these -> no RAM write, readdata=0 in ACK, bus_err=1:
//   - address[1:0]!=0
//   - word index >= MEM_WORDS, with index = (address-BASE_ADDR)>>2 as an
//     unsigned 32-bit subtraction, so addresses below BASE wrap and fault
//   - read&write both high
//  Read-after-write: the next transaction returns the newly written data.
//  Reset mid-transaction: aborts to IDLE. A pending write is not committed.
// CONFIGURATION
//  AVALON_MEM_JITTER_EN defined:
//   - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on Rst)
//     advances every cycle.
//   - On IDLE acceptance: count <= WAIT_CYCLES + lfsr[1:0], giving 0..3
//     extra waits.
//   - The core's waitrequest handling is exercised under variable latency.
//  Not defined: latency is exactly WAIT_CYCLES+1. No LFSR logic exists.
// STRUCTURE
//  mips_bus_pkg holds:
//   - state_t {IDLE, WAIT, ACK}
//   - BYTE_LANES=4
//   - the fault_t enum {NONE, MISALIGN, RANGE, RW_CONFLICT}
//  Sub-module lfsr16 (clk, Rst, q[15:0]) is instantiated only under
//   AVALON_MEM_JITTER_EN. The RAM array stays inline so it infers block RAM.
// TESTING
//  1 WAIT_CYCLES=2; write 0xDEADBEEF to BASE, be=4'hF.
//    -> waitrequest low exactly at t+3. A following read of BASE returns
//       0xDEADBEEF in its ACK.
//  2 Preload 0x11223344; write 0xAABBCCDD with be=4'b0101.
//    -> read returns 0x11BB33DD.
//  3 Read address BASE+2, then read BASE+4*MEM_WORDS.
//    -> each ACK has bus_err=1 and readdata=0; RAM unchanged.
//  4 Assert read and write together.
//    -> bus_err=1 in ACK; no RAM write.
//  5 Start a write; Rst=1 during WAIT.
//    -> next cycle IDLE, waitrequest=1; target word unchanged.
//  6 WAIT_CYCLES=0; issue 8 back-to-back reads with the request held.
//    -> ACK every 2nd cycle, 8 ACKs.
//    With AVALON_MEM_JITTER_EN: gaps between ACKs are 2..5 cycles; data still correct.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// ---------------------------------------------------------------------------
// mips_bus_pkg
//   Shared types and helpers for the multicycle MIPS core's memory bus.
//   - state_t      : responder handshake phases (IDLE -> WAIT -> ACK)
//   - fault_t      : reason an access is refused
//   - BYTE_LANES   : byte lanes per 32-bit bus word
//   - COUNT_W      : width of the wait-state counter (15 waits + 3 jitter)
//   - classify_access() : decides whether a request is legal
// ---------------------------------------------------------------------------
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    MISALIGN,
    RANGE,
    RW_CONFLICT
  } fault_t;

  localparam int BYTE_LANES = 4;
  localparam int COUNT_W    = 5;

  // The offset is an unsigned 32-bit difference, so an address below the
  // base wraps to a huge word index and lands in the RANGE fault.
  function automatic fault_t classify_access(
    input logic [31:0] addr,
    input logic        rd,
    input logic        wr,
    input logic [31:0] base,
    input logic [31:0] words
  );
    logic [31:0] offset;
    offset = addr - base;
    if (addr[1:0] != 2'b00) begin
      return MISALIGN;
    end else if ((offset >> 2) >= words) begin
      return RANGE;
    end else if (rd && wr) begin
      return RW_CONFLICT;
    end else begin
      return NONE;
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clock.
//   Used by the memory responder to add pseudo-random wait states.
// Ports
//   clk : clock
//   Rst : synchronous active-high reset, loads seed 16'hACE1
//   q   : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16 (
  input  logic        clk,
  input  logic        Rst,
  output logic [15:0] q
);

  logic feedback;

  // Taps 16,14,13,11 in 1-based numbering are bits 15,13,12,10.
  assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (Rst) begin
      q <= 16'hACE1;
    end else begin
      q <= {q[14:0], feedback};
    end
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// ---------------------------------------------------------------------------
// avalon_mem_responder
//   Memory-side responder for the multicycle MIPS core's bus. Accepts one
//   read or write at a time, stalls it with waitrequest for WAIT_CYCLES
//   cycles, then completes it in a single ACK cycle. Backing store is a
//   single-port word RAM with byte-lane write enables.
//
// Parameters
//   MEM_WORDS     : depth in 32-bit words (power of two, >= 2)
//   BASE_ADDR     : byte address of word 0
//   WAIT_CYCLES   : fixed wait states per access (0..15)
//   RAM_INIT_FILE : initial image name; the RAM is left unloaded here
//
// Ports
//   clk         : clock, all state changes on posedge
//   Rst         : synchronous active-high reset (RAM contents kept)
//   address     : byte address of the access
//   read        : read request
//   write       : write request
//   byteenable  : write lane mask, bit i covers writedata[8i+7:8i]
//   writedata   : write data
//   readdata    : read data, valid only in the ACK cycle, 0 elsewhere
//   waitrequest : 0 only in the ACK cycle
//   bus_err     : one-cycle pulse in the ACK of a faulted access
//
// Configuration
//   AVALON_MEM_JITTER_EN : when defined, an lfsr16 adds 0..3 extra wait
//   states to every access (lfsr[1:0] sampled at acceptance). When not
//   defined, latency is exactly WAIT_CYCLES+1 and no LFSR exists.
// ---------------------------------------------------------------------------
module avalon_mem_responder
  import mips_bus_pkg::*;
#(
  parameter int unsigned MEM_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES   = 2,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [BYTE_LANES-1:0] byteenable,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  output logic                  bus_err
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                state;
  logic [COUNT_W-1:0]    count;

  // Request captured in IDLE; later input changes are ignored.
  logic [31:0]           addr_q;
  logic                  read_q;
  logic                  write_q;
  logic [BYTE_LANES-1:0] be_q;
  logic [31:0]           wdata_q;

  logic [31:0]           mem [MEM_WORDS];

  // ---------------------------------------------------------------------
  // Wait-state load value (optional jitter)
  // ---------------------------------------------------------------------
  logic [1:0]         extra_waits;
  logic [COUNT_W-1:0] wait_load;

`ifdef AVALON_MEM_JITTER_EN
  logic [15:0] lfsr_q;
  logic        unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk (clk),
    .Rst (Rst),
    .q   (lfsr_q)
  );

  assign extra_waits      = lfsr_q[1:0];
  assign unused_lfsr_bits = ^lfsr_q[15:2];
`else
  assign extra_waits = 2'b00;
`endif

  assign wait_load = COUNT_W'(WAIT_CYCLES) + COUNT_W'(extra_waits);

  // ---------------------------------------------------------------------
  // Current access view: live inputs while IDLE (needed when the access
  // goes straight to ACK with zero waits), latched copy otherwise.
  // ---------------------------------------------------------------------
  logic [31:0]           cur_addr;
  logic                  cur_rd;
  logic                  cur_wr;
  logic [BYTE_LANES-1:0] cur_be;
  logic [31:0]           cur_wdata;
  logic                  cur_req;
  logic [ADDR_W-1:0]     cur_idx;
  fault_t                cur_fault;
  logic                  ack_fault;
  logic                  enter_ack;
  logic                  commit;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_addr  = addr_q;
    cur_rd    = read_q;
    cur_wr    = write_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_addr  = address;
      cur_rd    = read;
      cur_wr    = write;
      cur_be    = byteenable;
      cur_wdata = writedata;
    end
  end

  assign cur_req   = cur_rd | cur_wr;
  assign cur_idx   = ADDR_W'((cur_addr - BASE_ADDR) >> 2);
  assign cur_fault = classify_access(cur_addr, cur_rd, cur_wr, BASE_ADDR,
                                     32'(MEM_WORDS));
  assign ack_fault = (cur_fault != NONE);

  // High on the edge that moves the FSM into ACK.
  always_comb begin
    enter_ack = 1'b0;
    case (state)
      IDLE:    enter_ack = cur_req && (wait_load == '0);
      WAIT:    enter_ack = (count <= COUNT_W'(1));
      default: enter_ack = 1'b0;
    endcase
  end

  // A reset on the commit edge wins, so an aborted write never lands.
  assign commit = enter_ack && cur_wr && !ack_fault && !Rst;

  // ---------------------------------------------------------------------
  // RAM write port
  // ---------------------------------------------------------------------
  // NOTE: the RAM array has no reset; clearing it would block block-RAM
  // inference and its contents must survive Rst anyway.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (cur_be[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Handshake FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Rst) begin
      state       <= IDLE;
      count       <= '0;
      waitrequest <= 1'b1;
      readdata    <= '0;
      bus_err     <= 1'b0;
      addr_q      <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      waitrequest <= !enter_ack;
      bus_err     <= enter_ack && ack_fault;
      readdata    <= (enter_ack && cur_rd && !ack_fault) ? mem[cur_idx] : '0;

      case (state)
        IDLE: begin
          if (cur_req) begin
            addr_q  <= address;
            read_q  <= read;
            write_q <= write;
            be_q    <= byteenable;
            wdata_q <= writedata;
            count   <= wait_load;
            state   <= (wait_load == '0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          count <= count - COUNT_W'(1);
          if (count <= COUNT_W'(1)) begin
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
